// File: rtl/riscv_legacy_core.sv
// Single-cycle RV32I-subset core with decoder controls exposed for observation.
// Macros: INSTR_START_ADDR (reset word index, default 0); RISCV_LEGACY_SHIFT_EN enables shifts.

`ifndef INSTR_START_ADDR
`define INSTR_START_ADDR 0
`endif

package riscv_legacy_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4,
    ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9
  } alu_op_e;

  typedef enum logic {SRC_RS2 = 1'b0, SRC_IMM = 1'b1} alu_src_e;
  typedef enum logic [1:0] {RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2} res_src_e;
  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_ALU = 2'd2} pc_src_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
endpackage

module riscv_legacy_ctrl
  import riscv_legacy_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_reg_we,
  output logic       o_mem_we,
  output logic [2:0] o_imm_src,
  output logic [3:0] o_alu_ctrl,
  output logic       o_alu_src,
  output logic [1:0] o_res_src,
  output logic [1:0] o_pc_src
);
  imm_src_e w_imm_src;
  alu_op_e  w_alu_op;
  alu_src_e w_alu_src;
  res_src_e w_res_src;
  pc_src_e  w_jump_src;
  pc_src_e  w_pc_src;
  logic     w_reg_we;
  logic     w_mem_we;
  logic     w_branch;
  logic     w_op_ok;

  function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt, input logic is_r);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Shift encodings collapse to NOPs when the shifter is not built.
`ifdef RISCV_LEGACY_SHIFT_EN
  assign w_op_ok = 1'b1;
`else
  assign w_op_ok = !((i_funct3 == 3'b001) || (i_funct3 == 3'b101));
`endif

  always_comb begin
    w_reg_we   = 1'b0;
    w_mem_we   = 1'b0;
    w_imm_src  = IMM_I;
    w_alu_op   = ALU_ADD;
    w_alu_src  = SRC_RS2;
    w_res_src  = RES_ALU;
    w_jump_src = PC_PLUS4;
    w_branch   = 1'b0;
    case (i_opcode)
      OP_R: begin
        w_reg_we = w_op_ok;
        w_alu_op = f3_to_alu(i_funct3, i_funct7b5, 1'b1);
      end
      OP_IMM: begin
        w_reg_we  = w_op_ok;
        w_alu_src = SRC_IMM;
        w_alu_op  = f3_to_alu(i_funct3, i_funct7b5, 1'b0);
      end
      OP_LW: begin
        w_reg_we  = 1'b1;
        w_alu_src = SRC_IMM;
        w_res_src = RES_MEM;
      end
      OP_SW: begin
        w_mem_we  = 1'b1;
        w_imm_src = IMM_S;
        w_alu_src = SRC_IMM;
      end
      OP_BR: begin
        w_imm_src = IMM_B;
        w_alu_op  = ALU_SUB;
        w_branch  = 1'b1;
      end
      OP_JAL: begin
        w_reg_we   = 1'b1;
        w_imm_src  = IMM_J;
        w_res_src  = RES_PC4;
        w_jump_src = PC_IMM;
      end
      OP_JALR: begin
        w_reg_we   = 1'b1;
        w_alu_src  = SRC_IMM;
        w_res_src  = RES_PC4;
        w_jump_src = PC_ALU;
      end
      OP_LUI: begin
        w_reg_we  = 1'b1;
        w_imm_src = IMM_U;
        w_alu_src = SRC_IMM;
      end
      default: begin
        w_reg_we = 1'b0;
      end
    endcase
  end

  // Kept apart from the decoder so the zero flag does not feed back into it.
  always_comb begin
    w_pc_src = w_jump_src;
    if (w_branch) begin
      if (((i_funct3 == 3'b000) && i_zero) || ((i_funct3 == 3'b001) && !i_zero)) begin
        w_pc_src = PC_IMM;
      end else begin
        w_pc_src = PC_PLUS4;
      end
    end else begin
      w_pc_src = w_jump_src;
    end
  end

  assign o_reg_we   = w_reg_we;
  assign o_mem_we   = w_mem_we;
  assign o_imm_src  = w_imm_src;
  assign o_alu_ctrl = w_alu_op;
  assign o_alu_src  = w_alu_src;
  assign o_res_src  = w_res_src;
  assign o_pc_src   = w_pc_src;
endmodule

module riscv_legacy_regfile (
  input  logic        clk,
  input  logic        i_we,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] _reg [0:31];

  always_ff @(posedge clk) begin
    if (i_we && (i_wa != 5'd0)) begin
      _reg[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : _reg[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : _reg[i_ra2];
endmodule

module riscv_legacy_dp
  import riscv_legacy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_reg_we,
  input  logic [2:0]  i_imm_src,
  input  logic [3:0]  i_alu_ctrl,
  input  logic        i_alu_src,
  input  logic [1:0]  i_res_src,
  input  logic [1:0]  i_pc_src,
  output logic [31:0] o_pc,
  output logic [31:0] o_alu_out,
  output logic [31:0] o_wd_data,
  output logic        o_zero
);
  localparam logic [31:0] RESET_PC = 32'(`INSTR_START_ADDR) << 2;

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_target;
  logic [31:0] w_pc_next;
  logic [31:0] w_imm;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [31:0] w_alu;
  logic [31:0] w_result;

  riscv_legacy_regfile rf (
    .clk   (clk),
    .i_we  (i_reg_we & rst),
    .i_ra1 (i_instr[19:15]),
    .i_ra2 (i_instr[24:20]),
    .i_wa  (i_instr[11:7]),
    .i_wd  (w_result),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  always_comb begin
    case (i_imm_src)
      IMM_I:   w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:   w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   w_imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_J:   w_imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      IMM_U:   w_imm = {i_instr[31:12], 12'd0};
      default: w_imm = 32'd0;
    endcase
  end

  // lui reuses the ADD path with operand A forced to zero.
  assign w_src_a = (i_instr[6:0] == OP_LUI) ? 32'd0 : w_rd1;
  assign w_src_b = (i_alu_src == SRC_IMM) ? w_imm : w_rd2;

  always_comb begin
    case (i_alu_ctrl)
      ALU_ADD:  w_alu = w_src_a + w_src_b;
      ALU_SUB:  w_alu = w_src_a - w_src_b;
      ALU_AND:  w_alu = w_src_a & w_src_b;
      ALU_OR:   w_alu = w_src_a | w_src_b;
      ALU_XOR:  w_alu = w_src_a ^ w_src_b;
      ALU_SLT:  w_alu = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
      ALU_SLTU: w_alu = {31'd0, w_src_a < w_src_b};
`ifdef RISCV_LEGACY_SHIFT_EN
      ALU_SLL:  w_alu = w_src_a << w_src_b[4:0];
      ALU_SRL:  w_alu = w_src_a >> w_src_b[4:0];
      ALU_SRA:  w_alu = $unsigned($signed(w_src_a) >>> w_src_b[4:0]);
`endif
      default:  w_alu = 32'd0;
    endcase
  end

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_pc_target = r_pc + w_imm;

  always_comb begin
    case (i_res_src)
      RES_ALU: w_result = w_alu;
      RES_MEM: w_result = i_mem_rd_data;
      RES_PC4: w_result = w_pc_plus4;
      default: w_result = w_alu;
    endcase
  end

  always_comb begin
    case (i_pc_src)
      PC_PLUS4: w_pc_next = w_pc_plus4;
      PC_IMM:   w_pc_next = w_pc_target;
      PC_ALU:   w_pc_next = {w_alu[31:1], 1'b0};
      default:  w_pc_next = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc      = r_pc;
  assign o_alu_out = w_alu;
  assign o_wd_data = w_rd2;
  assign o_zero    = (w_alu == 32'd0);
endmodule

module riscv_legacy (
  input  logic        clk,
  input  logic        rst,
  output logic        reg_we,
  output logic        mem_we,
  output logic [2:0]  imm_src,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src,
  output logic [1:0]  res_src,
  output logic [1:0]  pc_src,
  output logic [31:0] instr,
  output logic [31:0] alu_out,
  output logic [31:0] mem_rd_data,
  output logic [31:0] mem_wd_data,
  output logic [31:0] pc
);
  localparam int MEM_WORDS = 64;

  // Contents are preloaded from outside; reset leaves both arrays untouched.
  logic [31:0] MEM_INSTR [0:MEM_WORDS-1];
  logic [31:0] MEM_DATA  [0:MEM_WORDS-1];
  logic        w_zero;

  assign instr       = MEM_INSTR[pc[7:2]];
  assign mem_rd_data = MEM_DATA[alu_out[7:2]];

  riscv_legacy_ctrl ctl (
    .i_opcode   (instr[6:0]),
    .i_funct3   (instr[14:12]),
    .i_funct7b5 (instr[30]),
    .i_zero     (w_zero),
    .o_reg_we   (reg_we),
    .o_mem_we   (mem_we),
    .o_imm_src  (imm_src),
    .o_alu_ctrl (alu_ctrl),
    .o_alu_src  (alu_src),
    .o_res_src  (res_src),
    .o_pc_src   (pc_src)
  );

  riscv_legacy_dp dp (
    .clk           (clk),
    .rst           (rst),
    .i_instr       (instr),
    .i_mem_rd_data (mem_rd_data),
    .i_reg_we      (reg_we),
    .i_imm_src     (imm_src),
    .i_alu_ctrl    (alu_ctrl),
    .i_alu_src     (alu_src),
    .i_res_src     (res_src),
    .i_pc_src      (pc_src),
    .o_pc          (pc),
    .o_alu_out     (alu_out),
    .o_wd_data     (mem_wd_data),
    .o_zero        (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      MEM_DATA[alu_out[7:2]] <= mem_wd_data;
    end
  end
endmodule

module riscv_legacy_core (
  input  logic        clk,
  input  logic        rst,
  output logic        reg_we,
  output logic        mem_we,
  output logic [2:0]  imm_src,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src,
  output logic [1:0]  res_src,
  output logic [1:0]  pc_src,
  output logic [31:0] instr,
  output logic [31:0] alu_out,
  output logic [31:0] mem_rd_data,
  output logic [31:0] mem_wd_data,
  output logic [31:0] pc
);
  riscv_legacy rv (
    .clk         (clk),
    .rst         (rst),
    .reg_we      (reg_we),
    .mem_we      (mem_we),
    .imm_src     (imm_src),
    .alu_ctrl    (alu_ctrl),
    .alu_src     (alu_src),
    .res_src     (res_src),
    .pc_src      (pc_src),
    .instr       (instr),
    .alu_out     (alu_out),
    .mem_rd_data (mem_rd_data),
    .mem_wd_data (mem_wd_data),
    .pc          (pc)
  );
endmodule

// File: tb/tb_riscv_legacy_core.sv
// Directed bench for riscv_legacy_core: single-instruction vector table plus
// hand-written store/load and mid-program reset sequences.

module tb_riscv_legacy_core;
  localparam logic [31:0] SENT = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_we;
  logic        mem_we;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl;
  logic        alu_src;
  logic [1:0]  res_src;
  logic [1:0]  pc_src;
  logic [31:0] instr;
  logic [31:0] alu_out;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_wd_data;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_legacy_core dut (
    .clk         (clk),
    .rst         (rst),
    .reg_we      (reg_we),
    .mem_we      (mem_we),
    .imm_src     (imm_src),
    .alu_ctrl    (alu_ctrl),
    .alu_src     (alu_src),
    .res_src     (res_src),
    .pc_src      (pc_src),
    .instr       (instr),
    .alu_out     (alu_out),
    .mem_rd_data (mem_rd_data),
    .mem_wd_data (mem_wd_data),
    .pc          (pc)
  );

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [4:0]  rd;
    logic [31:0] exp_rd;
    logic        exp_reg_we;
    logic        exp_mem_we;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  task automatic add_vec(input string nm, input logic [31:0] ins, input logic [4:0] rd,
                         input logic [31:0] exp_rd, input logic we, input logic mwe,
                         input logic [31:0] exp_pc);
    vec_t v;
    v.name = nm; v.ins = ins; v.rd = rd; v.exp_rd = exp_rd;
    v.exp_reg_we = we; v.exp_mem_we = mwe; v.exp_pc = exp_pc;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    dut.rv.dp.rf._reg[0]  = 32'd0;
    dut.rv.dp.rf._reg[5]  = 32'h8;
    dut.rv.dp.rf._reg[6]  = 32'd2;
    dut.rv.dp.rf._reg[7]  = 32'hFFFFFFF8;
    dut.rv.dp.rf._reg[8]  = 32'd2;
    dut.rv.dp.rf._reg[9]  = 32'd2;
    dut.rv.dp.rf._reg[10] = 32'd4;
    dut.rv.dp.rf._reg[14] = 32'd5;
    dut.rv.dp.rf._reg[15] = 32'd7;

    add_vec("sltu_a",  32'h0062b233, 5'd4, 32'd0, 1'b1, 1'b0, 32'd4);
    add_vec("sltu_b",  32'h0083b233, 5'd4, 32'd0, 1'b1, 1'b0, 32'd4);
    add_vec("sltu_c",  32'h00a4b233, 5'd4, 32'd1, 1'b1, 1'b0, 32'd4);
    add_vec("slt",     enc_r(7'h00, 5'd8, 5'd7, 3'd2, 5'd4, 7'h33), 5'd4, 32'd1, 1'b1, 1'b0, 32'd4);
    add_vec("sub",     enc_r(7'h20, 5'd15, 5'd14, 3'd0, 5'd4, 7'h33), 5'd4, 32'hFFFFFFFE, 1'b1, 1'b0, 32'd4);
    add_vec("add",     enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd4, 7'h33), 5'd4, 32'hA, 1'b1, 1'b0, 32'd4);
    add_vec("and",     enc_r(7'h00, 5'd5, 5'd7, 3'd7, 5'd4, 7'h33), 5'd4, 32'h8, 1'b1, 1'b0, 32'd4);
    add_vec("or",      enc_r(7'h00, 5'd5, 5'd6, 3'd6, 5'd4, 7'h33), 5'd4, 32'hA, 1'b1, 1'b0, 32'd4);
    add_vec("xor",     enc_r(7'h00, 5'd10, 5'd7, 3'd4, 5'd4, 7'h33), 5'd4, 32'hFFFFFFFC, 1'b1, 1'b0, 32'd4);
    add_vec("addi",    enc_i(12'hFFD, 5'd5, 3'd0, 5'd4, 7'h13), 5'd4, 32'd5, 1'b1, 1'b0, 32'd4);
    add_vec("andi",    enc_i(12'h0F0, 5'd7, 3'd7, 5'd4, 7'h13), 5'd4, 32'hF0, 1'b1, 1'b0, 32'd4);
    add_vec("ori",     enc_i(12'h100, 5'd6, 3'd6, 5'd4, 7'h13), 5'd4, 32'h102, 1'b1, 1'b0, 32'd4);
    add_vec("xori",    enc_i(12'hFFF, 5'd5, 3'd4, 5'd4, 7'h13), 5'd4, 32'hFFFFFFF7, 1'b1, 1'b0, 32'd4);
    add_vec("slti",    enc_i(12'h001, 5'd7, 3'd2, 5'd4, 7'h13), 5'd4, 32'd1, 1'b1, 1'b0, 32'd4);
    add_vec("sltiu",   enc_i(12'hFFF, 5'd5, 3'd3, 5'd4, 7'h13), 5'd4, 32'd1, 1'b1, 1'b0, 32'd4);
    add_vec("lui",     32'h12345237, 5'd4, 32'h12345000, 1'b1, 1'b0, 32'd4);
    add_vec("addi_x0", enc_i(12'h005, 5'd0, 3'd0, 5'd0, 7'h13), 5'd0, 32'd0, 1'b1, 1'b0, 32'd4);
    add_vec("unknown", 32'h0000027F, 5'd4, SENT, 1'b0, 1'b0, 32'd4);
    add_vec("beq_t",   enc_r(7'h00, 5'd8, 5'd6, 3'd0, 5'd8, 7'h63), 5'd4, SENT, 1'b0, 1'b0, 32'd8);
    add_vec("beq_nt",  enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd8, 7'h63), 5'd4, SENT, 1'b0, 1'b0, 32'd4);
    add_vec("bne_t",   enc_r(7'h00, 5'd6, 5'd5, 3'd1, 5'd8, 7'h63), 5'd4, SENT, 1'b0, 1'b0, 32'd8);
    add_vec("bne_nt",  enc_r(7'h00, 5'd8, 5'd6, 3'd1, 5'd8, 7'h63), 5'd4, SENT, 1'b0, 1'b0, 32'd4);
    add_vec("jal",     32'h008000EF, 5'd1, 32'd4, 1'b1, 1'b0, 32'd8);
    add_vec("jalr",    enc_i(12'h003, 5'd10, 3'd0, 5'd1, 7'h67), 5'd1, 32'd4, 1'b1, 1'b0, 32'd6);
`ifdef RISCV_LEGACY_SHIFT_EN
    add_vec("slli",    enc_i(12'h002, 5'd5, 3'd1, 5'd4, 7'h13), 5'd4, 32'd32, 1'b1, 1'b0, 32'd4);
    add_vec("srai",    enc_i(12'h401, 5'd7, 3'd5, 5'd4, 7'h13), 5'd4, 32'hFFFFFFFC, 1'b1, 1'b0, 32'd4);
    add_vec("sra",     enc_r(7'h20, 5'd6, 5'd7, 3'd5, 5'd4, 7'h33), 5'd4, 32'hFFFFFFFE, 1'b1, 1'b0, 32'd4);
`else
    add_vec("slli",    enc_i(12'h002, 5'd5, 3'd1, 5'd4, 7'h13), 5'd4, SENT, 1'b0, 1'b0, 32'd4);
    add_vec("srai",    enc_i(12'h401, 5'd7, 3'd5, 5'd4, 7'h13), 5'd4, SENT, 1'b0, 1'b0, 32'd4);
    add_vec("sra",     enc_r(7'h20, 5'd6, 5'd7, 3'd5, 5'd4, 7'h33), 5'd4, SENT, 1'b0, 1'b0, 32'd4);
`endif

    // Reset state: pc at start address, instr is the first program word.
    dut.rv.MEM_INSTR[0] = vq[0].ins;
    do_reset();
    chk("reset_pc", pc, 32'd0);
    chk("reset_instr", instr, 32'h0062b233);

    foreach (vq[i]) begin
      dut.rv.MEM_INSTR[0] = vq[i].ins;
      dut.rv.dp.rf._reg[vq[i].rd] = (vq[i].rd != 5'd0) ? SENT : 32'd0;
      do_reset();
      chk({vq[i].name, "_reg_we"}, {31'd0, reg_we}, {31'd0, vq[i].exp_reg_we});
      chk({vq[i].name, "_mem_we"}, {31'd0, mem_we}, {31'd0, vq[i].exp_mem_we});
      step();
      chk({vq[i].name, "_rd"}, dut.rv.dp.rf._reg[vq[i].rd], vq[i].exp_rd);
      chk({vq[i].name, "_pc"}, pc, vq[i].exp_pc);
    end

    // sw x5,0(x0) then lw x11,0(x0)
    dut.rv.MEM_INSTR[0]   = 32'h00502023;
    dut.rv.MEM_INSTR[1]   = 32'h00002583;
    dut.rv.MEM_DATA[0]    = 32'd0;
    dut.rv.dp.rf._reg[11] = SENT;
    do_reset();
    chk("sw_mem_we", {31'd0, mem_we}, 32'd1);
    chk("sw_reg_we", {31'd0, reg_we}, 32'd0);
    chk("sw_wdata", mem_wd_data, 32'h8);
    chk("sw_addr", alu_out, 32'd0);
    step();
    chk("sw_mem", dut.rv.MEM_DATA[0], 32'h8);
    chk("lw_rdata", mem_rd_data, 32'h8);
    chk("lw_mem_we", {31'd0, mem_we}, 32'd0);
    step();
    chk("lw_x11", dut.rv.dp.rf._reg[11], 32'h8);
    chk("lw_pc", pc, 32'd8);

    // Mid-program reset: the in-flight store and addi must not commit.
    dut.rv.MEM_INSTR[0]   = enc_i(12'h001, 5'd16, 3'd0, 5'd16, 7'h13);
    dut.rv.MEM_INSTR[1]   = 32'h00502223;
    dut.rv.MEM_INSTR[2]   = enc_i(12'h001, 5'd16, 3'd0, 5'd16, 7'h13);
    dut.rv.MEM_DATA[1]    = 32'd0;
    dut.rv.dp.rf._reg[16] = 32'd0;
    do_reset();
    step();
    chk("mr_x16_a", dut.rv.dp.rf._reg[16], 32'd1);
    chk("mr_pc_a", pc, 32'd4);
    rst = 1'b0;
    step();
    chk("mr_pc_rst1", pc, 32'd0);
    chk("mr_x16_rst1", dut.rv.dp.rf._reg[16], 32'd1);
    chk("mr_mem_rst1", dut.rv.MEM_DATA[1], 32'd0);
    rst = 1'b1;
    step();
    chk("mr_x16_b", dut.rv.dp.rf._reg[16], 32'd2);
    step();
    chk("mr_mem_b", dut.rv.MEM_DATA[1], 32'h8);
    chk("mr_pc_b", pc, 32'd8);
    rst = 1'b0;
    step();
    chk("mr_pc_rst2", pc, 32'd0);
    chk("mr_x16_rst2", dut.rv.dp.rf._reg[16], 32'd2);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
